reg_scoreboard: RTL and testbench

//  Register scoreboard and issue scheduler between Decode and the Data-Fetch/Schedule stage.

---
 rtl/scoreboard_pkg.sv | 43 ++++
 rtl/sb_counter.sv | 51 +++++
 rtl/reg_scoreboard.sv | 118 +++++++++++
 tb/tb_reg_scoreboard.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
//   reg_idx_t     : architectural register index (GPRs plus the stack register)
//   cnt_t         : per-register pending-writer counter
//   sb_state_e    : scheduler state (RUN / DRAIN / FLUSH)
//   count_matches : number of valid ports in a bundle that name a given register
package scoreboard_pkg;

  localparam int NREG    = 33;
  localparam int RW      = $clog2(NREG);
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NSRC    = 3;
  localparam int NDST    = 2;
  localparam int NWB     = 2;

  // Port bundles of up to MAXP entries are fed through count_matches;
  // narrower bundles are zero-extended by the caller. PCW holds 0..MAXP.
  localparam int MAXP = 4;
  localparam int PCW  = 3;

  typedef logic [RW-1:0]    reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

  function automatic logic [PCW-1:0] count_matches(
    input reg_idx_t            idx,
    input logic [MAXP-1:0]    vld,
    input logic [MAXP*RW-1:0] regs
  );
    logic [PCW-1:0] n;
    n = '0;
    for (int p = 0; p < MAXP; p++) begin
      if (vld[p] && (regs[p*RW +: RW] == idx)) n = n + PCW'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One pending-writer counter for a single architectural register.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous clear (branch flush), wins over inc/dec
//   inc        : number of claims this cycle (already gated by fire)
//   dec        : number of writeback releases this cycle
//   cnt        : current count
//   busy       : cnt != 0
//   underflow  : this cycle's releases exceed count plus claims
// Next value is cur + inc - dec, clamped to [0, CNT_MAX].
module sb_counter
  import scoreboard_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [PCW-1:0] inc,
  input  logic [PCW-1:0] dec,
  output cnt_t           cnt,
  output logic           busy,
  output logic           underflow
);

  localparam int SW = CNT_W + PCW;

  logic [SW-1:0] sum;
  cnt_t          cnt_nx;

  always_comb begin
    sum       = SW'(cnt) + SW'(inc);
    underflow = 1'b0;
    cnt_nx    = cnt;
    if (clear) begin
      cnt_nx = '0;
    end else if (SW'(dec) > sum) begin
      cnt_nx    = '0;
      underflow = 1'b1;
    end else if ((sum - SW'(dec)) > SW'(CNT_MAX)) begin
      cnt_nx = cnt_t'(CNT_MAX);
    end else begin
      cnt_nx = cnt_t'(sum - SW'(dec));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nx;
  end

  assign busy = |cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue scheduler between Decode and Data-Fetch.
//   clk, reset     : clock, asynchronous active-low reset
//   iss_*          : uop presented by Decode (sources, destinations, serialize)
//   iss_ready      : uop accepted this cycle
//   wb_vld/wb_reg  : writeback releases, one pending write per valid port
//   flush          : branch redirect, discards all pending state
//   sb_idle        : nothing pending and state RUN
//   sb_err         : sticky, a release hit a zero counter
//   sb_state       : current scheduler state (debug)
//   dbg_cnt        : all pending counters, register r at [r*CNT_W +: CNT_W] (debug)
//
// Handshake: Decode holds iss_valid and the uop fields stable; iss_ready is a
// combinational function of registered state plus this cycle's uop, flush and
// reset. The uop is taken (its destinations claimed) exactly when
// iss_valid && iss_ready at the rising edge; nothing else is implied.
module reg_scoreboard
  import scoreboard_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_valid,
  input  logic [NSRC-1:0]        iss_src_vld,
  input  logic [NSRC*RW-1:0]     iss_src_reg,
  input  logic [NDST-1:0]        iss_dst_vld,
  input  logic [NDST*RW-1:0]     iss_dst_reg,
  input  logic                   iss_serialize,
  output logic                   iss_ready,
  input  logic [NWB-1:0]         wb_vld,
  input  logic [NWB*RW-1:0]      wb_reg,
  input  logic                   flush,
  output logic                   sb_idle,
  output logic                   sb_err,
  output sb_state_e              sb_state,
  output logic [NREG*CNT_W-1:0]  dbg_cnt
);

  sb_state_e state, state_nx;

  logic [MAXP-1:0]    src_vld_x, dst_vld_x, wb_vld_x;
  logic [MAXP*RW-1:0] src_reg_x, dst_reg_x, wb_reg_x;

  logic [PCW-1:0] claim_req   [NREG];
  logic [PCW-1:0] release_req [NREG];
  logic [PCW-1:0] inc         [NREG];
  cnt_t           cnt         [NREG];

  logic [NREG-1:0] busy, uflow, src_use, dst_use, room_ok;
  logic            src_hit, dst_hit, all_zero, room_all, fire;

  assign src_vld_x = {{(MAXP-NSRC){1'b0}}, iss_src_vld};
  assign src_reg_x = {{((MAXP-NSRC)*RW){1'b0}}, iss_src_reg};
  assign dst_vld_x = {{(MAXP-NDST){1'b0}}, iss_dst_vld};
  assign dst_reg_x = {{((MAXP-NDST)*RW){1'b0}}, iss_dst_reg};
  assign wb_vld_x  = {{(MAXP-NWB){1'b0}}, wb_vld};
  assign wb_reg_x  = {{((MAXP-NWB)*RW){1'b0}}, wb_reg};

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam reg_idx_t IDX = reg_idx_t'(r);

    // Duplicate destinations in one uop both land here, so a claim can be 2.
    assign claim_req[r]   = count_matches(IDX, dst_vld_x, dst_reg_x);
    // Flush discards same-cycle writebacks entirely.
    assign release_req[r] = flush ? '0 : count_matches(IDX, wb_vld_x, wb_reg_x);
    assign src_use[r]     = |count_matches(IDX, src_vld_x, src_reg_x);
    assign dst_use[r]     = |claim_req[r];
    assign room_ok[r]     = (PCW'(cnt[r]) + claim_req[r]) <= PCW'(CNT_MAX);
    assign inc[r]         = fire ? claim_req[r] : '0;

    sb_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .inc       (inc[r]),
      .dec       (release_req[r]),
      .cnt       (cnt[r]),
      .busy      (busy[r]),
      .underflow (uflow[r])
    );

    assign dbg_cnt[r*CNT_W +: CNT_W] = cnt[r];
  end

  // Hazards use start-of-cycle counts only: a writeback in this cycle does
  // not unblock a dependent uop until the next cycle.
  assign src_hit  = |(src_use & busy);
  assign dst_hit  = |(dst_use & busy);
  assign all_zero = ~|busy;
  assign room_all = &room_ok;

  assign iss_ready = reset && (state == SB_RUN) && !flush && !src_hit &&
                     !dst_hit && room_all && (!iss_serialize || all_zero);
  assign fire      = iss_valid && iss_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      SB_RUN:   if (fire && iss_serialize) state_nx = SB_DRAIN;
      SB_DRAIN: if (all_zero) state_nx = SB_RUN;
      SB_FLUSH: state_nx = SB_RUN;
      default:  state_nx = SB_RUN;
    endcase
    if (flush) state_nx = SB_FLUSH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SB_RUN;
      sb_err <= 1'b0;
    end else begin
      state  <= state_nx;
      sb_err <= sb_err | (|uflow);
    end
  end

  assign sb_idle  = (state == SB_RUN) && all_zero;
  assign sb_state = state;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  import scoreboard_pkg::*;

  localparam int RAX = 0;
  localparam int RBX = 1;
  localparam int RDX = 2;
  localparam int R3  = 3;
  localparam int R7  = 7;
  localparam int RSP = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  iss_valid;
  logic [NSRC-1:0]       iss_src_vld;
  logic [NSRC*RW-1:0]    iss_src_reg;
  logic [NDST-1:0]       iss_dst_vld;
  logic [NDST*RW-1:0]    iss_dst_reg;
  logic                  iss_serialize;
  logic                  iss_ready;
  logic [NWB-1:0]        wb_vld;
  logic [NWB*RW-1:0]     wb_reg;
  logic                  flush;
  logic                  sb_idle;
  logic                  sb_err;
  sb_state_e             sb_state;
  logic [NREG*CNT_W-1:0] dbg_cnt;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .iss_valid     (iss_valid),
    .iss_src_vld   (iss_src_vld),
    .iss_src_reg   (iss_src_reg),
    .iss_dst_vld   (iss_dst_vld),
    .iss_dst_reg   (iss_dst_reg),
    .iss_serialize (iss_serialize),
    .iss_ready     (iss_ready),
    .wb_vld        (wb_vld),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .sb_idle       (sb_idle),
    .sb_err        (sb_err),
    .sb_state      (sb_state),
    .dbg_cnt       (dbg_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_cnt [NREG];
  sb_state_e m_state;
  bit        m_err;
  bit        exp_rdy;

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_state = SB_RUN;
    m_err   = 1'b0;
  endfunction

  function automatic bit model_ready();
    int claims [NREG];
    bit any_busy;
    int idx;
    if (reset !== 1'b1) return 1'b0;
    if (m_state != SB_RUN || flush) return 1'b0;
    any_busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      claims[r] = 0;
      if (m_cnt[r] != 0) any_busy = 1'b1;
    end
    for (int s = 0; s < NSRC; s++) begin
      if (iss_src_vld[s]) begin
        idx = int'(iss_src_reg[s*RW +: RW]);
        if (idx < NREG && m_cnt[idx] != 0) return 1'b0;
      end
    end
    for (int d = 0; d < NDST; d++) begin
      if (iss_dst_vld[d]) begin
        idx = int'(iss_dst_reg[d*RW +: RW]);
        if (idx < NREG) begin
          if (m_cnt[idx] != 0) return 1'b0;
          claims[idx]++;
        end
      end
    end
    for (int r = 0; r < NREG; r++) if (m_cnt[r] + claims[r] > CNT_MAX) return 1'b0;
    if (iss_serialize && any_busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit rdy);
    int delta [NREG];
    bit zero_before;
    bit fire;
    int idx;
    int n;
    zero_before = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      delta[r] = 0;
      if (m_cnt[r] != 0) zero_before = 1'b0;
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_state = SB_FLUSH;
      return;
    end
    fire = iss_valid && rdy;
    if (fire) begin
      for (int d = 0; d < NDST; d++) begin
        idx = int'(iss_dst_reg[d*RW +: RW]);
        if (iss_dst_vld[d] && idx < NREG) delta[idx] += 1;
      end
    end
    for (int w = 0; w < NWB; w++) begin
      idx = int'(wb_reg[w*RW +: RW]);
      if (wb_vld[w] && idx < NREG) delta[idx] -= 1;
    end
    for (int r = 0; r < NREG; r++) begin
      n = m_cnt[r] + delta[r];
      if (n < 0) begin
        n     = 0;
        m_err = 1'b1;
      end
      if (n > CNT_MAX) n = CNT_MAX;
      m_cnt[r] = n;
    end
    case (m_state)
      SB_RUN:   if (fire && iss_serialize) m_state = SB_DRAIN;
      SB_DRAIN: if (zero_before) m_state = SB_RUN;
      default:  m_state = SB_RUN;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic model_check();
    logic [NREG*CNT_W-1:0] exp_vec;
    bit all_zero;
    exp_rdy  = model_ready();
    all_zero = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      exp_vec[r*CNT_W +: CNT_W] = CNT_W'(m_cnt[r]);
      if (m_cnt[r] != 0) all_zero = 1'b0;
    end
    chk("ready", 80'(iss_ready), 80'(exp_rdy));
    chk("idle",  80'(sb_idle), 80'((m_state == SB_RUN) && all_zero));
    chk("err",   80'(sb_err), 80'(m_err));
    chk("state", 80'(sb_state), 80'(m_state));
    chk("cnt",   80'(dbg_cnt), 80'(exp_vec));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic run_cycle();
    #1;
    model_check();
    @(posedge clk);
    if (reset) model_step(exp_rdy);
    else       model_reset();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    iss_valid     = 1'b0;
    iss_src_vld   = '0;
    iss_src_reg   = '0;
    iss_dst_vld   = '0;
    iss_dst_reg   = '0;
    iss_serialize = 1'b0;
    wb_vld        = '0;
    wb_reg        = '0;
    flush         = 1'b0;
  endtask

  typedef struct {
    logic      valid;
    logic      sv;
    reg_idx_t  s0;
    logic [1:0] dv;
    reg_idx_t  d0, d1;
    logic      ser;
    logic [1:0] wbv;
    reg_idx_t  w0, w1;
    logic      fl;
    logic      er;
    sb_state_e es;
    reg_idx_t  ck;
    cnt_t      ec;
    logic      ee;
  } vec_t;

  function automatic vec_t v(input int valid, input int sv, input int s0, input int dv,
                             input int d0, input int d1, input int ser, input int wbv,
                             input int w0, input int w1, input int fl, input int er,
                             input sb_state_e es, input int ck, input int ec, input int ee);
    vec_t t;
    t.valid = 1'(valid); t.sv = 1'(sv); t.s0 = RW'(s0);
    t.dv = 2'(dv); t.d0 = RW'(d0); t.d1 = RW'(d1); t.ser = 1'(ser);
    t.wbv = 2'(wbv); t.w0 = RW'(w0); t.w1 = RW'(w1); t.fl = 1'(fl);
    t.er = 1'(er); t.es = es; t.ck = RW'(ck); t.ec = CNT_W'(ec); t.ee = 1'(ee);
    return t;
  endfunction

  task automatic apply_vec(input vec_t t);
    drive_idle();
    iss_valid          = t.valid;
    iss_src_vld[0]     = t.sv;
    iss_src_reg[0 +: RW] = t.s0;
    iss_dst_vld        = t.dv;
    iss_dst_reg[0 +: RW]  = t.d0;
    iss_dst_reg[RW +: RW] = t.d1;
    iss_serialize      = t.ser;
    wb_vld             = t.wbv;
    wb_reg[0 +: RW]    = t.w0;
    wb_reg[RW +: RW]   = t.w1;
    flush              = t.fl;
  endtask

  function automatic reg_idx_t rnd_reg();
    if ($urandom_range(0, 7) == 0) return reg_idx_t'(RSP);
    return reg_idx_t'($urandom_range(0, 7));
  endfunction

  function automatic reg_idx_t rnd_wb_reg();
    int pend[$];
    for (int r = 0; r < NREG; r++) if (m_cnt[r] != 0) pend.push_back(r);
    if (pend.size() > 0 && $urandom_range(0, 3) != 0)
      return reg_idx_t'(pend[$urandom_range(0, pend.size() - 1)]);
    return rnd_reg();
  endfunction

  task automatic drive_random();
    drive_idle();
    iss_valid     = ($urandom_range(0, 3) != 0);
    iss_src_vld   = NSRC'($urandom_range(0, (1 << NSRC) - 1));
    iss_dst_vld   = NDST'($urandom_range(0, (1 << NDST) - 1));
    for (int s = 0; s < NSRC; s++) iss_src_reg[s*RW +: RW] = rnd_reg();
    for (int d = 0; d < NDST; d++) iss_dst_reg[d*RW +: RW] = rnd_reg();
    iss_serialize = ($urandom_range(0, 19) == 0);
    for (int w = 0; w < NWB; w++) begin
      wb_vld[w]            = ($urandom_range(0, 2) == 0);
      wb_reg[w*RW +: RW]   = rnd_wb_reg();
    end
    flush         = ($urandom_range(0, 59) == 0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    // Directed vectors: per-cycle inputs and hand-derived expectations
    // (ready, state, one register's count, sb_err) seen before the edge.
    //                valid sv s0  dv d0  d1  ser wbv w0  w1  fl er es        ck  ec ee
    tbl.push_back(v(1, 0, 0,  1, R3, 0,  0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 0));
    tbl.push_back(v(1, 1, R3, 0, 0,  0,  0, 0, 0,  0,  0, 0, SB_RUN,   R3,  1, 0));
    tbl.push_back(v(1, 1, R3, 0, 0,  0,  0, 1, R3, 0,  0, 0, SB_RUN,   R3,  1, 0));
    tbl.push_back(v(1, 1, R3, 0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 0));
    tbl.push_back(v(1, 0, 0,  3, RSP,RAX,0, 0, 0,  0,  0, 1, SB_RUN,   RSP, 0, 0));
    tbl.push_back(v(1, 0, 0,  1, RBX,0,  0, 1, RSP,0,  0, 1, SB_RUN,   RSP, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   RSP, 0, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   RAX, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 3, RBX,RAX,0, 1, SB_RUN,   RBX, 1, 0));
    tbl.push_back(v(1, 0, 0,  1, RAX,0,  0, 0, 0,  0,  0, 1, SB_RUN,   RAX, 0, 0));
    tbl.push_back(v(1, 0, 0,  1, RDX,0,  1, 0, 0,  0,  0, 0, SB_RUN,   RAX, 1, 0));
    tbl.push_back(v(1, 0, 0,  1, RDX,0,  1, 1, RAX,0,  0, 0, SB_RUN,   RAX, 1, 0));
    tbl.push_back(v(1, 0, 0,  1, RDX,0,  1, 0, 0,  0,  0, 1, SB_RUN,   RAX, 0, 0));
    tbl.push_back(v(1, 0, 0,  1, R7, 0,  0, 0, 0,  0,  0, 0, SB_DRAIN, RDX, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 1, RDX,0,  0, 0, SB_DRAIN, RDX, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 0, SB_DRAIN, RDX, 0, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   RDX, 0, 0));
    tbl.push_back(v(1, 0, 0,  3, R3, R7, 0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 0));
    tbl.push_back(v(1, 0, 0,  1, RAX,0,  0, 0, 0,  0,  0, 1, SB_RUN,   R7,  1, 0));
    tbl.push_back(v(1, 0, 0,  1, RBX,0,  0, 1, R3, 0,  1, 0, SB_RUN,   R3,  1, 0));
    tbl.push_back(v(1, 0, 0,  1, RBX,0,  0, 0, 0,  0,  0, 0, SB_FLUSH, R7,  0, 0));
    tbl.push_back(v(1, 0, 0,  1, RBX,0,  0, 0, 0,  0,  0, 1, SB_RUN,   RBX, 0, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 1, RBX,0,  0, 1, SB_RUN,   RBX, 1, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 1, R7, 0,  0, 1, SB_RUN,   R7,  0, 0));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   R7,  0, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  1, 0, SB_RUN,   R7,  0, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  1, 0, SB_FLUSH, R7,  0, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 0, SB_FLUSH, R7,  0, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   R7,  0, 1));
    tbl.push_back(v(1, 0, 0,  3, R3, R3, 0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 1));
    tbl.push_back(v(1, 0, 0,  1, R3, 0,  0, 0, 0,  0,  0, 0, SB_RUN,   R3,  2, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 3, R3, R3, 0, 1, SB_RUN,   R3,  2, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 1));
    tbl.push_back(v(1, 0, 0,  3, R3, R3, 0, 0, 0,  0,  0, 1, SB_RUN,   R3,  0, 1));
    tbl.push_back(v(0, 0, 0,  0, 0,  0,  0, 0, 0,  0,  0, 1, SB_RUN,   R3,  2, 1));

    // Power-on reset
    drive_idle();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("por_ready", 80'(iss_ready), 80'(0));
    chk("por_cnt",   80'(dbg_cnt), 80'(0));
    chk("por_err",   80'(sb_err), 80'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      apply_vec(tbl[k]);
      #1;
      chk($sformatf("vec%0d_ready", k), 80'(iss_ready), 80'(tbl[k].er));
      chk($sformatf("vec%0d_state", k), 80'(sb_state), 80'(tbl[k].es));
      chk($sformatf("vec%0d_cnt", k),
          80'(dbg_cnt[int'(tbl[k].ck)*CNT_W +: CNT_W]), 80'(tbl[k].ec));
      chk($sformatf("vec%0d_err", k), 80'(sb_err), 80'(tbl[k].ee));
      run_cycle();
    end

    // Reset mid-operation with R3 at 2 and sb_err set, issue held valid.
    apply_vec(v(1, 0, 0, 1, RAX, 0, 0, 1, R7, 0, 0, 0, SB_RUN, 0, 0, 0));
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 80'(iss_ready), 80'(0));
    chk("mid_rst_cnt",   80'(dbg_cnt), 80'(0));
    chk("mid_rst_err",   80'(sb_err), 80'(0));
    chk("mid_rst_state", 80'(sb_state), 80'(SB_RUN));
    model_reset();
    run_cycle();
    run_cycle();
    drive_idle();
    reset = 1'b1;
    #1;
    chk("post_rst_idle",  80'(sb_idle), 80'(1));
    chk("post_rst_ready", 80'(iss_ready), 80'(1));
    run_cycle();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      run_cycle();
    end

    // Drain everything out with a flush and confirm the idle state
    drive_idle();
    flush = 1'b1;
    run_cycle();
    drive_idle();
    run_cycle();
    run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
